usb_rx_frontend: RTL



---
 rtl/usb_rx_frontend.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/usb_rx_frontend.sv
// USB receive front end: NRZI decode, SYNC detect, bit unstuffing and EOP detection.
// Build option: define SYNC_LOOSE_EN to accept a truncated SYNC (newest decoded bits 0,0,0,1).
module usb_rx_frontend #(
    parameter int MAX_BITS  = 99,
    parameter int STUFF_RUN = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic sampleEn,
    input  logic dp,
    input  logic dm,
    input  logic readyIn,
    output logic bitOut,
    output logic bitOutAvail,
    output logic done,
    output logic rxErr,
    output logic active
);
    localparam int CNT_W  = $clog2(MAX_BITS + 2);
    localparam int ONES_W = $clog2(STUFF_RUN + 1);

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_EOP1,
        ST_EOP2,
        ST_ABORT
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          prev_line_q, prev_line_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]          sync_sr_q, sync_sr_d;
    logic                bit_out_q, bit_out_d;
    logic                bit_out_avail_q, bit_out_avail_d;
    logic                done_q, done_d;
    logic                rx_err_q, rx_err_d;
    logic                active_q, active_d;

    logic [1:0]          line;
    logic                is_jk;
    logic                dec_bit;
    logic [7:0]          sync_shift;
    logic                sync_hit;
    logic                abort;

    assign line       = {dp, dm};
    assign is_jk      = (line == LINE_J) || (line == LINE_K);
    assign dec_bit    = (line == prev_line_q);
    assign sync_shift = {sync_sr_q[6:0], dec_bit};

`ifdef SYNC_LOOSE_EN
    assign sync_hit = (sync_shift[3:0] == 4'b0001);
`else
    assign sync_hit = (sync_shift == 8'h01);
`endif

    always_comb begin
        state_d         = state_q;
        prev_line_d     = prev_line_q;
        ones_d          = ones_q;
        bit_cnt_d       = bit_cnt_q;
        sync_sr_d       = sync_sr_q;
        bit_out_d       = bit_out_q;
        bit_out_avail_d = 1'b0;
        done_d          = 1'b0;
        rx_err_d        = 1'b0;
        active_d        = active_q;
        abort           = 1'b0;

        if (sampleEn) begin
            prev_line_d = line;
            case (state_q)
                ST_IDLE: begin
                    if (!is_jk) begin
                        sync_sr_d = 8'hFF;
                    end else begin
                        sync_sr_d = sync_shift;
                        // The closing SYNC 1 already counts toward the stuffing run.
                        if (sync_hit && readyIn) begin
                            state_d   = ST_DATA;
                            active_d  = 1'b1;
                            ones_d    = ONES_W'(1);
                            bit_cnt_d = '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (line == LINE_SE0) begin
                        state_d = ST_EOP1;
                    end else if (line == LINE_SE1) begin
                        abort = 1'b1;
                    end else if (ones_q == ONES_W'(STUFF_RUN)) begin
                        if (dec_bit) begin
                            abort = 1'b1;
                        end else begin
                            ones_d = '0;
                        end
                    end else if (bit_cnt_q == CNT_W'(MAX_BITS)) begin
                        abort = 1'b1;
                    end else begin
                        bit_out_d       = dec_bit;
                        bit_out_avail_d = 1'b1;
                        bit_cnt_d       = bit_cnt_q + CNT_W'(1);
                        ones_d          = dec_bit ? ones_q + ONES_W'(1) : '0;
                    end
                end
                ST_EOP1: begin
                    if (line == LINE_SE0) begin
                        state_d = ST_EOP2;
                    end else begin
                        abort = 1'b1;
                    end
                end
                ST_EOP2: begin
                    if (line == LINE_J) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        active_d    = 1'b0;
                        sync_sr_d   = 8'hFF;
                        prev_line_d = LINE_J;
                    end else begin
                        abort = 1'b1;
                    end
                end
                ST_ABORT: begin
                    if (line == LINE_J) begin
                        state_d   = ST_IDLE;
                        sync_sr_d = 8'hFF;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (abort) begin
                state_d  = ST_ABORT;
                done_d   = 1'b1;
                rx_err_d = 1'b1;
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            prev_line_q     <= LINE_J;
            ones_q          <= '0;
            bit_cnt_q       <= '0;
            sync_sr_q       <= 8'hFF;
            bit_out_q       <= 1'b0;
            bit_out_avail_q <= 1'b0;
            done_q          <= 1'b0;
            rx_err_q        <= 1'b0;
            active_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            prev_line_q     <= prev_line_d;
            ones_q          <= ones_d;
            bit_cnt_q       <= bit_cnt_d;
            sync_sr_q       <= sync_sr_d;
            bit_out_q       <= bit_out_d;
            bit_out_avail_q <= bit_out_avail_d;
            done_q          <= done_d;
            rx_err_q        <= rx_err_d;
            active_q        <= active_d;
        end
    end

    assign bitOut      = bit_out_q;
    assign bitOutAvail = bit_out_avail_q;
    assign done        = done_q;
    assign rxErr       = rx_err_q;
    assign active      = active_q;

endmodule
